flopenr: RTL and testbench

- Parameterised D-type register with load enable and synchronous, active-low reset.
- Generic storage primitive for the MIPS datapath: PC, pipeline and holding registers.
- Captures d on the rising edge of clk when en is high; otherwise holds its value.
- Default configuration is a 1-bit flop.

---
 rtl/flopenr_pkg.sv | 26 ++
 rtl/flopenr_bit.sv | 52 +++++
 rtl/flopenr.sv | 86 ++++++++
 tb/tb_flopenr.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/flopenr_pkg.sv
// ---------------------------------------------------------------------------
// flopenr_pkg
//   Shared constants and helpers for the flopenr enable/reset register.
//
//   Contents:
//     DEFAULT_WIDTH     - default data width of flopenr (a single flop).
//     PARITY_MAX_WIDTH  - widest vector calc_parity accepts. Callers
//                         zero-extend to this width. Zero bits do not
//                         change an XOR reduction.
//     calc_parity()     - XOR reduction (even-parity bit) of a vector.
//
//   Optional feature macro used by importers: FLOPENR_PARITY_EN.
// ---------------------------------------------------------------------------
package flopenr_pkg;

    localparam int DEFAULT_WIDTH    = 1;
    localparam int PARITY_MAX_WIDTH = 256;

    // XOR reduction of a zero-extended vector. Data wider than
    // PARITY_MAX_WIDTH would be truncated, so keep WIDTH at or below it
    // when parity is enabled.
    function automatic logic calc_parity(input logic [PARITY_MAX_WIDTH-1:0] i_vec);
        return ^i_vec;
    endfunction

endpackage : flopenr_pkg

// File: rtl/flopenr_bit.sv
// ---------------------------------------------------------------------------
// flopenr_bit
//   One-bit register cell with load enable and synchronous, active-low
//   reset. The enable is a recirculating mux in front of the flop, so the
//   clock is never gated.
//
//   Parameters:
//     RESET_BIT - value loaded while rst is low.
//
//   Ports:
//     clk   in   clock, rising edge active
//     rst   in   synchronous reset, active low (0 = reset)
//     i_en  in   load enable, active high
//     i_d   in   data to capture
//     o_q   out  registered output
// ---------------------------------------------------------------------------
module flopenr_bit #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic r_q;
    logic w_next;

    // Hold path: with the enable low the flop reloads its own value.
    // A ternary rather than an if/else keeps an X on i_en visible on the
    // next state instead of silently selecting the hold branch.
    // NOTE: a combinational block must assign its output on every path,
    //       otherwise a latch is inferred; the ternary covers both cases.
    always_comb begin
        w_next = i_en ? i_d : r_q;
    end

    // NOTE: rst is deliberately absent from the sensitivity list, which
    //       makes the reset synchronous. State is written with <= so every
    //       flop samples pre-edge values regardless of process order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= RESET_BIT;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_q = r_q;

endmodule : flopenr_bit

// File: rtl/flopenr.sv
// ---------------------------------------------------------------------------
// flopenr
//   Parameterised D register with load enable and synchronous, active-low
//   reset. It is the generic storage element of the MIPS datapath (PC,
//   pipeline and holding registers).
//
//   Priority at each rising edge of clk:
//     rst == 0           -> q <= RESET_VALUE
//     rst == 1, en == 1  -> q <= d
//     rst == 1, en == 0  -> q holds
//
//   Parameters:
//     WIDTH        - data width, 1 or more
//     RESET_VALUE  - value loaded into q on a reset edge
//
//   Ports:
//     clk         in   clock, rising edge active
//     rst         in   synchronous reset, active low
//     en          in   load enable, active high
//     d           in   [WIDTH] data to capture
//     q           out  [WIDTH] registered data
//     parity_err  out  only with FLOPENR_PARITY_EN: stored parity does not
//                      match the parity of q
//
//   Optional feature macro: FLOPENR_PARITY_EN. When it is defined, a parity
//   bit is stored next to q and checked combinationally against it.
//   WIDTH must not exceed PARITY_MAX_WIDTH in that build.
// ---------------------------------------------------------------------------
module flopenr
    import flopenr_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
`ifdef FLOPENR_PARITY_EN
    output logic [WIDTH-1:0] q,
    output logic             parity_err
`else
    output logic [WIDTH-1:0] q
`endif
);

    // One cell per data bit. Each cell takes its own reset bit from
    // RESET_VALUE, so any reset pattern costs nothing extra.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        flopenr_bit #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .i_en (en),
            .i_d  (d[i]),
            .o_q  (q[i])
        );
    end

`ifdef FLOPENR_PARITY_EN
    localparam logic RESET_PARITY = calc_parity(PARITY_MAX_WIDTH'(RESET_VALUE));

    logic w_parity_d;
    logic w_parity_q;

    assign w_parity_d = calc_parity(PARITY_MAX_WIDTH'(d));

    // The parity bit shares the same reset and enable as the data, so it
    // always describes the value q was last reset or loaded with.
    flopenr_bit #(
        .RESET_BIT (RESET_PARITY)
    ) u_parity (
        .clk  (clk),
        .rst  (rst),
        .i_en (en),
        .i_d  (w_parity_d),
        .o_q  (w_parity_q)
    );

    // Both operands are registered, so this is a check on stored state.
    // It adds no path from d, en or rst to q.
    assign parity_err = calc_parity(PARITY_MAX_WIDTH'(q)) != w_parity_q;
`endif

endmodule : flopenr

// File: tb/tb_flopenr.sv
// ---------------------------------------------------------------------------
// tb_flopenr
//   Drives two flopenr instances from a common clk/rst/en:
//     u_dut1 - default build (WIDTH=1, RESET_VALUE=0)
//     u_dut8 - WIDTH=8, RESET_VALUE=8'hA5
//   A reference model records, edge by edge, the value each register must
//   hold. A compare process checks both instances against it 1 ns after
//   every rising edge. Directed steps also pin results to literal values.
//   When FLOPENR_PARITY_EN is defined, parity_err is checked as well, and
//   a forced bit flip in the stored data must raise it.
// ---------------------------------------------------------------------------
module tb_flopenr;

    localparam logic [7:0] RV8 = 8'hA5;

    logic       clk;
    logic       rst;
    logic       en;
    logic [0:0] d1;
    logic [0:0] q1;
    logic [7:0] d8;
    logic [7:0] q8;
`ifdef FLOPENR_PARITY_EN
    logic       perr1;
    logic       perr8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [0:0] m1;
    logic [7:0] m8;
    bit         m_valid   = 1'b0; // q is defined only after a reset or a load
    bit         check_en  = 1'b1; // compare process is paused while forcing

    flopenr u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .d          (d1),
`ifdef FLOPENR_PARITY_EN
        .q          (q1),
        .parity_err (perr1)
`else
        .q          (q1)
`endif
    );

    flopenr #(
        .WIDTH       (8),
        .RESET_VALUE (RV8)
    ) u_dut8 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .d          (d8),
`ifdef FLOPENR_PARITY_EN
        .q          (q8),
        .parity_err (perr8)
`else
        .q          (q8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the value a register must hold after an edge, given only the
    // inputs present at that edge. After the update it checks the DUT.
    always @(posedge clk) begin
        if (rst === 1'b0) begin
            m1      = 1'b0;
            m8      = RV8;
            m_valid = 1'b1;
        end else if (en === 1'b1) begin
            m1      = d1;
            m8      = d8;
            m_valid = 1'b1;
        end
        #1;
        if (m_valid && check_en) begin
            check("model_q1", 32'(q1), 32'(m1));
            check("model_q8", 32'(q8), 32'(m8));
`ifdef FLOPENR_PARITY_EN
            check("model_perr1", 32'(perr1), 32'd0);
            check("model_perr8", 32'(perr8), 32'd0);
`endif
        end
    end

    // Apply inputs at the falling edge, then wait until the following
    // rising edge has been checked.
    task automatic step(input logic r, input logic e, input logic [0:0] v1, input logic [7:0] v8);
        @(negedge clk);
        rst = r;
        en  = e;
        d1  = v1;
        d8  = v8;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        d1  = '0;
        d8  = '0;

        // Reset wins over a pending load
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        check("reset_q1", 32'(q1), 32'd0);
        check("reset_q8", 32'(q8), 32'hA5);

        // Load, then load the opposite value
        step(1'b1, 1'b1, 1'b1, 8'h3C);
        check("load1_q1", 32'(q1), 32'd1);
        check("load1_q8", 32'(q8), 32'h3C);
        step(1'b1, 1'b1, 1'b0, 8'h00);
        check("load0_q1", 32'(q1), 32'd0);
        check("load0_q8", 32'(q8), 32'h00);

        // Hold for three edges with d at the opposite value
        step(1'b1, 1'b1, 1'b1, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            check("hold_q1", 32'(q1), 32'd1);
            check("hold_q8", 32'(q8), 32'h5A);
        end

        // Priority: reset with en high, then load on release
        step(1'b0, 1'b1, 1'b1, 8'hFF);
        check("prio_rst_q1", 32'(q1), 32'd0);
        check("prio_rst_q8", 32'(q8), 32'hA5);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        check("prio_load_q1", 32'(q1), 32'd1);
        check("prio_load_q8", 32'(q8), 32'hFF);

        // Glitch rst, en and d between edges, with a hold at the edge
        @(negedge clk);
        rst = 1'b1; en = 1'b0; d1 = 1'b0; d8 = 8'h00;
        #1 rst = 1'b0; en = 1'b1; d1 = 1'b0; d8 = 8'h11;
        #1 d1 = 1'b1; d8 = 8'h22;
        #1 rst = 1'b1; en = 1'b0; d1 = 1'b0; d8 = 8'h33;
        @(posedge clk);
        #2;
        check("glitch_q1", 32'(q1), 32'd1);
        check("glitch_q8", 32'(q8), 32'hFF);

        // Randomised traffic, checked every edge by the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(7) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(1)),
                 1'($urandom_range(1)),
                 8'($urandom));
        end

`ifdef FLOPENR_PARITY_EN
        begin
            logic flipped;
            step(1'b0, 1'b0, 1'b0, 8'h00);
            check("par_rst_q8", 32'(q8), 32'hA5);
            check("par_rst_perr8", 32'(perr8), 32'd0);
            step(1'b1, 1'b1, 1'b0, 8'h3C);
            check("par_load_q8", 32'(q8), 32'h3C);
            check("par_load_perr8", 32'(perr8), 32'd0);

            // Corrupt one stored data bit
            @(negedge clk);
            check_en = 1'b0;
            en       = 1'b0;
            flipped  = ~q8[3];
            force u_dut8.g_bits[3].u_bit.r_q = flipped;
            #1;
            check("flip_q8", 32'(q8), 32'h34);
            check("flip_perr8", 32'(perr8), 32'd1);
            release u_dut8.g_bits[3].u_bit.r_q;

            // Reset clears the corruption
            step(1'b0, 1'b0, 1'b0, 8'h00);
            check_en = 1'b1;
            check("par_clr_q8", 32'(q8), 32'hA5);
            check("par_clr_perr8", 32'(perr8), 32'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_flopenr
